// File: rtl/sd_dma.sv
// Block DMA: polls the SD byte engine for a data token, then stores one data block
// into shared memory at a programmed base, stealing two CPU cycles per byte.
module sd_dma #(
  parameter int         BLOCK_LEN   = 512,
  parameter int         CRC_LEN     = 2,
  parameter int         TOKEN_TRIES = 4096,
  parameter logic [1:0] CMD_XFER    = 2'd1,
  parameter logic [7:0] FILL        = 8'hFF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [19:0] base,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_wreq,
  output logic        cpu_locked,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wreq
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam int TRY_W = $clog2(TOKEN_TRIES + 1);
  localparam int CRC_W = $clog2(CRC_LEN + 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_POLL  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_TOKEN = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_T_REQ, S_T_HI, S_T_LO,
    S_D_REQ, S_D_HI, S_D_LO,
    S_GRANT, S_WRITE,
    S_C_REQ, S_C_HI, S_C_LO,
    S_FIN, S_ERR
  } state_t;

  state_t           state_q;
  logic [19:0]      base_q;
  logic [7:0]       byte_q;
  logic [CNT_W-1:0] count_q;
  logic [TRY_W-1:0] tries_q;
  logic [CRC_W-1:0] crc_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       error_q;
  logic             sd_signal_q;
  logic             cpu_locked_q;
  logic             grant_q;
  logic             hs_wait;
  logic             grant_d;

  // Handshake wait states are where an engine timeout aborts the transfer.
  assign hs_wait = (state_q == S_T_HI) || (state_q == S_T_LO) ||
                   (state_q == S_D_HI) || (state_q == S_D_LO) ||
                   (state_q == S_C_HI) || (state_q == S_C_LO);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      tries_q      <= '0;
      crc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= ERR_OK;
      sd_signal_q  <= 1'b0;
      cpu_locked_q <= 1'b1;
      grant_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      sd_signal_q <= 1'b0;
      if (hs_wait && sd_timeout) begin
        error_q <= ERR_TMO;
        busy_q  <= 1'b0;
        state_q <= S_ERR;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              base_q      <= base;
              count_q     <= '0;
              tries_q     <= '0;
              crc_q       <= '0;
              error_q     <= ERR_OK;
              busy_q      <= 1'b1;
              sd_signal_q <= 1'b1;
              state_q     <= S_T_REQ;
            end
          end
          S_T_REQ: state_q <= S_T_HI;
          S_T_HI:  if (sd_busy) state_q <= S_T_LO;
          S_T_LO: begin
            if (!sd_busy) begin
              if (sd_din == 8'hFF) begin
                tries_q <= tries_q + 1'b1;
                if (tries_q == TRY_W'(TOKEN_TRIES - 1)) begin
                  error_q <= ERR_POLL;
                  busy_q  <= 1'b0;
                  state_q <= S_ERR;
                end else begin
                  sd_signal_q <= 1'b1;
                  state_q     <= S_T_REQ;
                end
              end else if (sd_din == 8'hFE) begin
                sd_signal_q <= 1'b1;
                state_q     <= S_D_REQ;
              end else begin
                error_q <= ERR_TOKEN;
                busy_q  <= 1'b0;
                state_q <= S_ERR;
              end
            end
          end
          S_D_REQ: state_q <= S_D_HI;
          S_D_HI:  if (sd_busy) state_q <= S_D_LO;
          S_D_LO: begin
            if (!sd_busy) begin
              byte_q       <= sd_din;
              cpu_locked_q <= 1'b0;
              state_q      <= S_GRANT;
            end
          end
          // One idle locked cycle lets the CPU's in-flight write retire first.
          S_GRANT: begin
            grant_q <= 1'b1;
            state_q <= S_WRITE;
          end
          S_WRITE: begin
            grant_q      <= 1'b0;
            cpu_locked_q <= 1'b1;
            count_q      <= count_q + 1'b1;
            sd_signal_q  <= 1'b1;
            state_q      <= (count_q == CNT_W'(BLOCK_LEN - 1)) ? S_C_REQ : S_D_REQ;
          end
          S_C_REQ: state_q <= S_C_HI;
          S_C_HI:  if (sd_busy) state_q <= S_C_LO;
          S_C_LO: begin
            if (!sd_busy) begin
              if (crc_q == CRC_W'(CRC_LEN - 1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_FIN;
              end else begin
                crc_q       <= crc_q + 1'b1;
                sd_signal_q <= 1'b1;
                state_q     <= S_C_REQ;
              end
            end
          end
          S_FIN:   state_q <= S_IDLE;
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Gating with resetn keeps a write that coincides with the reset cycle off the bus.
  assign grant_d     = grant_q & resetn;
  assign mem_address = grant_d ? (base_q + 20'(count_q)) : cpu_address;
  assign mem_data    = grant_d ? byte_q : cpu_data;
  assign mem_wreq    = grant_d ? 1'b1 : cpu_wreq;

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign sd_signal  = sd_signal_q;
  assign sd_cmd     = CMD_XFER;
  assign sd_out     = FILL;
  assign cpu_locked = cpu_locked_q;

endmodule
